// File: rtl/motor_accel_pwm_if.sv
// Control/status bundle between direction_control and one H-bridge channel.
// master drives MC; slave (motor_accel_pwm) drives the bridge and debug outputs.
interface motor_accel_pwm_if #(
   parameter int PWM_BITS = 8
);
   logic [4:0]          MC;
   logic                PWM_OUT;
   logic                DIR_OUT;
   logic                EN_OUT;
   logic [PWM_BITS-1:0] DUTY;
   logic [1:0]          STATE;

   modport master (
      output MC,
      input  PWM_OUT, DIR_OUT, EN_OUT, DUTY, STATE
   );

   modport slave (
      input  MC,
      output PWM_OUT, DIR_OUT, EN_OUT, DUTY, STATE
   );
endinterface

// File: rtl/motor_accel_pwm.sv
// One H-bridge channel: rate-limited PWM duty ramp with a forced
// decel-to-zero and dead time before any direction reversal.
module motor_accel_pwm #(
   parameter int PWM_BITS   = 8,
   parameter int STEP_DIV   = 50000,
   parameter int LEVEL_STEP = 4,
   parameter int DEADTIME   = 1000
) (
   input  logic CLK,
   input  logic RST_N,
   motor_accel_pwm_if.slave bus
);

   localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

   localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(LEVEL_STEP);
   localparam logic [TW-1:0] TICK_LAST = TW'(STEP_DIV - 1);
   localparam logic [DW-1:0] DEAD_LOAD = DW'(DEADTIME - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      DECEL = 2'b10,
      DEAD  = 2'b11
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic                dir;
   logic                dir_nxt;
   logic [DW-1:0]       dead_cnt;
   logic [DW-1:0]       dead_nxt;
   logic [TW-1:0]       tick_cnt;
   logic                tick;
   logic [PWM_BITS-1:0] duty;
   logic [PWM_BITS-1:0] duty_nxt;
   logic [PWM_BITS-1:0] tgt;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [PWM_BITS-1:0] act_duty;
   logic                pwm_q;
   logic                en;
   logic                req_ok;
   logic                req_dir;

   // MC[0] set means neutral (01/11); MC[1] then selects reverse.
   assign req_ok  = ~bus.MC[0];
   assign req_dir = bus.MC[1];
   assign tgt     = {bus.MC[4:2], {(PWM_BITS-3){1'b0}}};
   assign tick    = (tick_cnt == TICK_LAST);
   assign en      = (state == RUN) || (state == DECEL);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + TW'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      dir_nxt   = dir;
      dead_nxt  = dead_cnt;
      case (state)
         IDLE: begin
            if (req_ok) begin
               state_nxt = RUN;
               dir_nxt   = req_dir;
            end
         end
         RUN: begin
            if (!req_ok || (req_dir != dir)) begin
               state_nxt = DECEL;
            end
         end
         DECEL: begin
            if (req_ok && (req_dir == dir)) begin
               state_nxt = RUN;
            end else if (duty == '0) begin
               state_nxt = DEAD;
               dead_nxt  = DEAD_LOAD;
            end
         end
         DEAD: begin
            if (dead_cnt == '0) begin
               if (req_ok) begin
                  state_nxt = RUN;
                  dir_nxt   = req_dir;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               dead_nxt = dead_cnt - DW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Duty follows the rule of the state present on the tick cycle.
   always_comb begin
      duty_nxt = duty;
      case (state)
         RUN: begin
            if (tick) begin
               if (duty < tgt) begin
                  duty_nxt = ((tgt - duty) > STEP) ? duty + STEP : tgt;
               end else if (duty > tgt) begin
                  duty_nxt = ((duty - tgt) > STEP) ? duty - STEP : tgt;
               end
            end
         end
         DECEL: begin
            if (tick) begin
               duty_nxt = (duty > STEP) ? duty - STEP : '0;
            end
         end
         default: duty_nxt = '0;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= IDLE;
         dir      <= 1'b0;
         dead_cnt <= '0;
         duty     <= '0;
      end else begin
         state    <= state_nxt;
         dir      <= dir_nxt;
         dead_cnt <= dead_nxt;
         duty     <= duty_nxt;
      end
   end

   // Active duty only changes at period wrap, so no runt pulses.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pwm_cnt  <= '0;
         act_duty <= '0;
         pwm_q    <= 1'b0;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_BITS'(1);
         if (pwm_cnt == '1) begin
            act_duty <= duty;
         end
         pwm_q <= en && (pwm_cnt < act_duty);
      end
   end

   assign bus.PWM_OUT = pwm_q;
   assign bus.DIR_OUT = dir;
   assign bus.EN_OUT  = en;
   assign bus.DUTY    = duty;
   assign bus.STATE   = state;

endmodule

// File: tb/tb_motor_accel_pwm.sv
// Randomized and directed bench for motor_accel_pwm against a
// cycle-level arithmetic model of the channel behaviour.
module tb_motor_accel_pwm;

   localparam int PB   = 8;
   localparam int SDIV = 4;
   localparam int LSTP = 4;
   localparam int DT   = 8;
   localparam int PER  = 1 << PB;

   logic       clk;
   logic       rst_n;
   logic [4:0] mc;

   int n_vec;
   int n_err;

   int m_st;
   int m_dir;
   int m_duty;
   int m_tick;
   int m_left;
   int m_pcnt;
   int m_act;
   int m_pwm;

   motor_accel_pwm_if #(.PWM_BITS(PB)) bus ();

   assign bus.MC = mc;

   motor_accel_pwm #(
      .PWM_BITS  (PB),
      .STEP_DIV  (SDIV),
      .LEVEL_STEP(LSTP),
      .DEADTIME  (DT)
   ) dut (
      .CLK  (clk),
      .RST_N(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st   = 0;
      m_dir  = 0;
      m_duty = 0;
      m_tick = 0;
      m_left = 0;
      m_pcnt = 0;
      m_act  = 0;
      m_pwm  = 0;
   endtask

   // One clock of the channel, using the MC held across this edge.
   task automatic model_step();
      int  tgt;
      int  req;
      int  nd;
      int  nst;
      int  ndir;
      bit  tk;
      tk  = (m_tick == SDIV - 1);
      tgt = int'(mc[4:2]) * (PER / 8);
      req = (mc[1:0] == 2'b00) ? 0 : (mc[1:0] == 2'b10) ? 1 : -1;
      nd  = m_duty;
      if (m_st == 1) begin
         if (tk && m_duty < tgt) nd = (m_duty + LSTP > tgt) ? tgt : m_duty + LSTP;
         else if (tk) nd = (m_duty - LSTP < tgt) ? tgt : m_duty - LSTP;
      end else if (m_st == 2) begin
         if (tk) nd = (m_duty < LSTP) ? 0 : m_duty - LSTP;
      end else begin
         nd = 0;
      end
      m_pwm = ((m_st == 1 || m_st == 2) && m_pcnt < m_act) ? 1 : 0;
      if (m_pcnt == PER - 1) m_act = m_duty;
      m_pcnt = (m_pcnt + 1) % PER;
      nst  = m_st;
      ndir = m_dir;
      case (m_st)
         0: if (req >= 0) begin nst = 1; ndir = req; end
         1: if (req != m_dir) nst = 2;
         2: begin
            if (req == m_dir) nst = 1;
            else if (m_duty == 0) begin nst = 3; m_left = DT; end
         end
         default: begin
            m_left--;
            if (m_left == 0) begin
               if (req < 0) nst = 0;
               else begin nst = 1; ndir = req; end
            end
         end
      endcase
      m_st   = nst;
      m_dir  = ndir;
      m_duty = nd;
      m_tick = (m_tick + 1) % SDIV;
   endtask

   task automatic cmp_all();
      chk("state", int'(bus.STATE), m_st);
      chk("dir", int'(bus.DIR_OUT), m_dir);
      chk("en", int'(bus.EN_OUT), (m_st == 1 || m_st == 2) ? 1 : 0);
      chk("duty", int'(bus.DUTY), m_duty);
      chk("pwm", int'(bus.PWM_OUT), m_pwm);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      model_step();
      cmp_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_state"}, int'(bus.STATE), 0);
      chk({tag, "_dir"}, int'(bus.DIR_OUT), 0);
      chk({tag, "_en"}, int'(bus.EN_OUT), 0);
      chk({tag, "_duty"}, int'(bus.DUTY), 0);
      chk({tag, "_pwm"}, int'(bus.PWM_OUT), 0);
   endtask

   // Asynchronous assert between edges, checked before any clock edge.
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("async_rst");
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_duty(input string tag, input int v);
      int i;
      i = 0;
      while (i < 300 && int'(bus.DUTY) != v) begin
         cyc();
         i++;
      end
      chk(tag, int'(bus.DUTY), v);
   endtask

   initial begin
      int hi;
      int dead_n;
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      mc    = 5'b00001;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_zero("por");
      @(negedge clk);
      rst_n = 1'b1;

      // Forward ramp to full command.
      mc = 5'b11100;
      cyc();
      chk("go_state", int'(bus.STATE), 1);
      chk("go_en", int'(bus.EN_OUT), 1);
      run(240);
      chk("ramp_top", int'(bus.DUTY), 224);
      run(260);
      hi = 0;
      for (int i = 0; i < PER; i++) begin
         cyc();
         hi += int'(bus.PWM_OUT);
      end
      chk("pwm_hi", hi, 224);

      // Lower target: ramp down to 96 while staying in RUN.
      mc = 5'b01100;
      run(136);
      chk("retgt_duty", int'(bus.DUTY), 96);
      chk("retgt_state", int'(bus.STATE), 1);
      mc = 5'b11100;
      run(136);
      chk("back_top", int'(bus.DUTY), 224);

      // Neutral then same direction again: resume from DECEL.
      mc = 5'b11101;
      wait_duty("hit200", 200);
      mc = 5'b11100;
      dead_n = 0;
      for (int i = 0; i < 60; i++) begin
         cyc();
         if (bus.STATE == 2'b11) dead_n++;
      end
      chk("resume_nodead", dead_n, 0);
      chk("resume_dir", int'(bus.DIR_OUT), 0);
      chk("resume_duty", int'(bus.DUTY), 224);

      // Reversal: decel to 0, exactly DT dead clocks, then reverse.
      mc = 5'b11110;
      dead_n = 0;
      for (int i = 0; i < 300; i++) begin
         cyc();
         if (bus.STATE == 2'b11 && !bus.EN_OUT) dead_n++;
      end
      chk("dead_len", dead_n, DT);
      chk("rev_dir", int'(bus.DIR_OUT), 1);
      chk("rev_state", int'(bus.STATE), 1);
      run(240);
      chk("rev_top", int'(bus.DUTY), 224);

      // Reset in the middle of a deceleration.
      mc = 5'b11101;
      wait_duty("hit120", 120);
      chk("mid_decel", int'(bus.STATE), 2);
      mc = 5'b11110;
      do_reset();
      cyc();
      chk("post_rst_state", int'(bus.STATE), 1);
      chk("post_rst_dir", int'(bus.DIR_OUT), 1);
      chk("post_rst_duty", int'(bus.DUTY), 0);
      run(40);

      // Randomized command sequences with occasional resets.
      for (int i = 0; i < 5000; i++) begin
         if ($urandom_range(0, 59) == 0) mc = 5'($urandom);
         if ($urandom_range(0, 1999) == 0) do_reset();
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
